// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: request/data bus between clients, the arbiter and the shared register
interface reg_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IDXW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       ack;
  logic                     reg_load;
  logic [WIDTH-1:0]         reg_d;
  logic [WIDTH-1:0]         reg_q;
  logic                     busy;
  logic [IDXW-1:0]          owner;
  logic                     verify_err;
  modport master (
    output req, wdata, reg_q,
    input  ack, reg_load, reg_d, busy, owner, verify_err
  );
  modport slave (
    input  req, wdata, reg_q,
    output ack, reg_load, reg_d, busy, owner, verify_err
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin sharing of one load-enabled register, with readback verify
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_write_arbiter_if.slave bus
);
  localparam int IDXW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;
  state_t               state_q, state_d;
  logic [IDXW-1:0]      owner_q, owner_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 load_q, load_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [IDXW-1:0]      win, cand;
  // scan downward from owner+NUM_REQ to owner+1 so the nearest requester after owner wins
  always_comb begin
    win  = owner_q;
    cand = owner_q;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDXW'((int'(owner_q) + i) % NUM_REQ);
      if (bus.req[cand]) win = cand;
    end
  end
  // next-state and registered-output decode for IDLE -> LOAD -> ACK
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    data_d  = data_q;
    load_d  = 1'b0;
    ack_d   = '0;
    if (state_q == IDLE && |bus.req) begin
      state_d = LOAD;
      owner_d = win;
      data_d  = bus.wdata[int'(win)*WIDTH +: WIDTH];
      load_d  = 1'b1;
    end else if (state_q == LOAD) begin
      state_d        = ACK;
      ack_d[owner_q] = 1'b1;
    end else if (state_q == ACK) begin
      state_d = IDLE;
    end
  end
  // state and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= IDXW'(NUM_REQ - 1);
      data_q  <= '0;
      load_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      load_q  <= load_d;
      ack_q   <= ack_d;
    end
  end
  assign bus.reg_load   = load_q;
  assign bus.reg_d      = data_q;
  assign bus.ack        = ack_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = state_q != IDLE;
  // readback is only meaningful after the LOAD edge, so compare during ACK
  assign bus.verify_err = (state_q == ACK) && (bus.reg_q != data_q);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed checks of arbitration, handshake, reset abort and readback verify
module tb_reg_write_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stuck = 1'b0;
  logic [WIDTH-1:0] mem;
  int pass_cnt = 0;
  int total = 0;
  reg_write_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus();
  reg_write_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '0;
    else if (bus.reg_load) mem <= bus.reg_d;
  end
  assign bus.reg_q = stuck ? '0 : mem;
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset;
    bus.req = '0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic test_reset;
    int seen;
    bus.req = '0;
    bus.wdata = '0;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    total++; if (bus.owner !== 2'd3) $display("FAIL reset_owner: got %0d exp 3", bus.owner); else pass_cnt++;
    total++; if (bus.reg_d !== 8'h00) $display("FAIL reset_reg_d: got %h exp 00", bus.reg_d); else pass_cnt++;
    total++; if ({bus.busy, bus.reg_load, bus.ack, bus.verify_err} !== 7'b0) $display("FAIL reset_outputs: got %b exp 0", {bus.busy, bus.reg_load, bus.ack, bus.verify_err}); else pass_cnt++;
    bus.req = 4'b0001;
    bus.wdata[7:0] = 8'h77;
    cyc();
    total++; if (bus.reg_load !== 1'b1) $display("FAIL midload_load: got %b exp 1", bus.reg_load); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.reg_load !== 1'b0) $display("FAIL async_load_drop: got %b exp 0", bus.reg_load); else pass_cnt++;
    bus.req = '0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.ack !== 4'b0 || bus.reg_load !== 1'b0) seen++;
    end
    total++; if (seen !== 0) $display("FAIL reset_no_ack: got %0d bad cycles exp 0", seen); else pass_cnt++;
    rst_n = 1'b1;
    cyc();
    total++; if (bus.busy !== 1'b0) $display("FAIL post_reset_busy: got %b exp 0", bus.busy); else pass_cnt++;
    total++; if (bus.owner !== 2'd3) $display("FAIL post_reset_owner: got %0d exp 3", bus.owner); else pass_cnt++;
    total++; if (bus.reg_d !== 8'h00) $display("FAIL post_reset_reg_d: got %h exp 00", bus.reg_d); else pass_cnt++;
  endtask
  task automatic test_single;
    bus.wdata = {8'h99, 8'hA5, 8'h88, 8'h77};
    bus.req = 4'b0100;
    cyc();
    total++; if (bus.reg_load !== 1'b1) $display("FAIL single_load: got %b exp 1", bus.reg_load); else pass_cnt++;
    total++; if (bus.reg_d !== 8'hA5) $display("FAIL single_reg_d: got %h exp a5", bus.reg_d); else pass_cnt++;
    total++; if (bus.ack !== 4'b0000) $display("FAIL single_early_ack: got %b exp 0000", bus.ack); else pass_cnt++;
    cyc();
    total++; if (bus.ack !== 4'b0100) $display("FAIL single_ack: got %b exp 0100", bus.ack); else pass_cnt++;
    total++; if (bus.verify_err !== 1'b0) $display("FAIL single_verify: got %b exp 0", bus.verify_err); else pass_cnt++;
    total++; if (bus.reg_load !== 1'b0) $display("FAIL single_load_off: got %b exp 0", bus.reg_load); else pass_cnt++;
    bus.req = '0;
    cyc();
    total++; if (bus.busy !== 1'b0) $display("FAIL single_busy: got %b exp 0", bus.busy); else pass_cnt++;
    total++; if (bus.owner !== 2'd2) $display("FAIL single_owner: got %0d exp 2", bus.owner); else pass_cnt++;
    total++; if (bus.reg_q !== 8'hA5) $display("FAIL single_readback: got %h exp a5", bus.reg_q); else pass_cnt++;
  endtask
  task automatic test_contention;
    int acks;
    int idx;
    logic [3:0] exp_ack;
    logic [7:0] exp_q;
    do_reset();
    bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req = 4'b1111;
    acks = 0;
    for (int c = 1; c <= 12 && acks < 4; c++) begin
      cyc();
      if (bus.ack !== 4'b0) begin
        exp_ack = 4'b0001 << acks;
        exp_q = 8'h11 * 8'(acks + 1);
        idx = 0;
        for (int j = 0; j < NUM_REQ; j++) if (bus.ack[j]) idx = j;
        total++; if (bus.ack !== exp_ack) $display("FAIL contention_ack%0d: got %b exp %b", acks, bus.ack, exp_ack); else pass_cnt++;
        total++; if (c !== 2 + 3 * acks) $display("FAIL contention_cycle%0d: got %0d exp %0d", acks, c, 2 + 3 * acks); else pass_cnt++;
        total++; if (bus.reg_q !== exp_q) $display("FAIL contention_data%0d: got %h exp %h", acks, bus.reg_q, exp_q); else pass_cnt++;
        bus.req[idx] = 1'b0;
        acks++;
      end
    end
    total++; if (acks !== 4) $display("FAIL contention_count: got %0d exp 4", acks); else pass_cnt++;
    bus.req = '0;
    cyc();
  endtask
  task automatic test_wrap;
    total++; if (bus.owner !== 2'd3) $display("FAIL wrap_start_owner: got %0d exp 3", bus.owner); else pass_cnt++;
    bus.wdata = {8'hC3, 8'h00, 8'h00, 8'h0F};
    bus.req = 4'b1001;
    cyc();
    total++; if (bus.owner !== 2'd0) $display("FAIL wrap_owner0: got %0d exp 0", bus.owner); else pass_cnt++;
    total++; if (bus.reg_d !== 8'h0F) $display("FAIL wrap_data0: got %h exp 0f", bus.reg_d); else pass_cnt++;
    cyc();
    total++; if (bus.ack !== 4'b0001) $display("FAIL wrap_ack0: got %b exp 0001", bus.ack); else pass_cnt++;
    bus.req[0] = 1'b0;
    cyc();
    cyc();
    total++; if (bus.owner !== 2'd3) $display("FAIL wrap_owner3: got %0d exp 3", bus.owner); else pass_cnt++;
    total++; if (bus.reg_d !== 8'hC3) $display("FAIL wrap_data3: got %h exp c3", bus.reg_d); else pass_cnt++;
    cyc();
    total++; if (bus.ack !== 4'b1000) $display("FAIL wrap_ack3: got %b exp 1000", bus.ack); else pass_cnt++;
    bus.req = '0;
    cyc();
  endtask
  task automatic test_readback_fault;
    stuck = 1'b1;
    bus.wdata[15:8] = 8'h3C;
    bus.req = 4'b0010;
    cyc();
    total++; if (bus.reg_d !== 8'h3C) $display("FAIL fault_reg_d: got %h exp 3c", bus.reg_d); else pass_cnt++;
    cyc();
    total++; if (bus.ack !== 4'b0010) $display("FAIL fault_ack: got %b exp 0010", bus.ack); else pass_cnt++;
    total++; if (bus.verify_err !== 1'b1) $display("FAIL fault_verify: got %b exp 1", bus.verify_err); else pass_cnt++;
    bus.req = '0;
    cyc();
    total++; if (bus.verify_err !== 1'b0) $display("FAIL fault_verify_pulse: got %b exp 0", bus.verify_err); else pass_cnt++;
    stuck = 1'b0;
  endtask
  task automatic test_early_drop;
    bus.wdata[15:8] = 8'h5A;
    bus.req = 4'b0010;
    cyc();
    bus.req = '0;
    bus.wdata[15:8] = 8'hFF;
    total++; if (bus.reg_load !== 1'b1) $display("FAIL drop_load: got %b exp 1", bus.reg_load); else pass_cnt++;
    total++; if (bus.reg_d !== 8'h5A) $display("FAIL drop_reg_d: got %h exp 5a", bus.reg_d); else pass_cnt++;
    cyc();
    total++; if (bus.ack !== 4'b0010) $display("FAIL drop_ack: got %b exp 0010", bus.ack); else pass_cnt++;
    total++; if (bus.reg_q !== 8'h5A) $display("FAIL drop_readback: got %h exp 5a", bus.reg_q); else pass_cnt++;
    total++; if (bus.verify_err !== 1'b0) $display("FAIL drop_verify: got %b exp 0", bus.verify_err); else pass_cnt++;
    cyc();
    total++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0) $display("FAIL drop_idle: got busy %b ack %b exp 0 0000", bus.busy, bus.ack); else pass_cnt++;
    total++; if (bus.reg_d !== 8'h5A) $display("FAIL drop_reg_d_hold: got %h exp 5a", bus.reg_d); else pass_cnt++;
  endtask
  initial begin
    bus.req = '0;
    bus.wdata = '0;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_readback_fault();
    test_early_drop();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
